// File: rtl/sram_port_initiator_pkg.sv
// rtl/sram_port_initiator_pkg.sv - shared types and helpers for the SRAM port initiator
package sram_port_initiator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } state_e;

  function automatic int credit_width(input int resp_depth);
    return $clog2(resp_depth + 1);
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - synchronous FIFO with head-of-queue output and optional fall-through
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned CntW = ADDR_DEPTH + 1;
  localparam logic [ADDR_DEPTH-1:0] LastPtr = ADDR_DEPTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_DEPTH-1:0] rptr_q;
  logic [ADDR_DEPTH-1:0] wptr_q;
  logic [CntW-1:0]       cnt_q;
  logic                  bypass;
  logic                  store;
  logic                  consume;

  // In fall-through mode an empty FIFO forwards a same-cycle push straight to a pop.
  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign bypass  = FALL_THROUGH && (cnt_q == '0) && push_i && pop_i;
  assign empty_o = (cnt_q == '0) && !(FALL_THROUGH && push_i);
  assign data_o  = (FALL_THROUGH && (cnt_q == '0)) ? data_i : mem_q[rptr_q];
  assign store   = push_i && !full_o && !bypass;
  assign consume = pop_i && !empty_o && !bypass;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (store) begin
        wptr_q <= (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
      end
      if (consume) begin
        rptr_q <= (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
      end
      cnt_q <= cnt_q + CntW'(store) - CntW'(consume);
    end
  end

  always_ff @(posedge clk_i) begin
    if (store) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/sram_port_initiator.sv
// rtl/sram_port_initiator.sv - valid/ready request front-end for a byte-enabled single-port SRAM
// Issues SRAM strobes, tracks reads across the macro latency and returns data under credit control.
module sram_port_initiator
  import sram_port_initiator_pkg::*;
#(
  parameter int unsigned NumWords    = 1024,
  parameter int unsigned DataWidth   = 128,
  parameter int unsigned ByteWidth   = 8,
  parameter int unsigned Latency     = 1,
  parameter int unsigned RespDepth   = 3,
  parameter bit          InitOnReset = 1'b1,
  parameter int unsigned AddrWidth   = (NumWords > 1) ? $clog2(NumWords) : 1,
  parameter int unsigned BeWidth     = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 init_done_o,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  localparam int unsigned CntWidth = credit_width(RespDepth);
  localparam logic [AddrWidth-1:0] LastAddr   = AddrWidth'(NumWords - 1);
  localparam logic [CntWidth-1:0]  MaxCredits = CntWidth'(RespDepth);

  state_e               state_q;
  logic [AddrWidth-1:0] init_cnt_q;
  logic [CntWidth-1:0]  credits_q, credits_d;
  logic [Latency-1:0]   rd_pipe_q, rd_pipe_d;
  logic                 req_hs, rd_hs, rsp_hs, mature;
  logic                 fifo_full, fifo_empty, fifo_rst_n;
  logic [DataWidth-1:0] fifo_rdata;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      init_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q    <= InitOnReset ? INIT : RUN;
          init_cnt_q <= '0;
        end
        INIT: begin
          if (init_cnt_q == LastAddr) begin
            state_q <= RUN;
          end
          init_cnt_q <= init_cnt_q + 1'b1;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // Credits count reads accepted but not yet popped, so the FIFO can always absorb them.
  assign init_done_o = (state_q == RUN);
  assign req_ready_o = (state_q == RUN) && (credits_q < MaxCredits);
  assign req_hs      = req_valid_i && req_ready_o;
  assign rd_hs       = req_hs && !req_we_i;
  assign rsp_hs      = rsp_valid_o && rsp_ready_i;

  always_comb begin
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (state_q == INIT) begin
      sram_req_o  = 1'b1;
      sram_we_o   = 1'b1;
      sram_addr_o = init_cnt_q;
      sram_be_o   = '1;
    end else if (req_hs) begin
      sram_req_o   = 1'b1;
      sram_we_o    = req_we_i;
      sram_addr_o  = req_addr_i;
      sram_wdata_o = req_wdata_i;
      sram_be_o    = req_be_i;
    end
  end

  always_comb begin
    credits_d = credits_q;
    if (rd_hs && !rsp_hs) begin
      credits_d = credits_q + CntWidth'(1);
    end else if (!rd_hs && rsp_hs) begin
      credits_d = credits_q - CntWidth'(1);
    end
  end

  if (Latency == 1) begin : gen_pipe_single
    assign rd_pipe_d = rd_hs;
  end else begin : gen_pipe_multi
    assign rd_pipe_d = {rd_pipe_q[Latency-2:0], rd_hs};
  end

  assign mature = rd_pipe_q[Latency-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      credits_q <= '0;
      rd_pipe_q <= '0;
    end else begin
      credits_q <= credits_d;
      rd_pipe_q <= rd_pipe_d;
    end
  end

  assign fifo_rst_n = !rst_i;

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (DataWidth),
    .DEPTH        (RespDepth)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (fifo_rst_n),
    .flush_i (1'b0),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_i  (sram_rdata_i),
    .push_i  (mature),
    .data_o  (fifo_rdata),
    .pop_i   (rsp_hs)
  );

  assign rsp_valid_o = !fifo_empty;
  assign rsp_rdata_o = fifo_empty ? '0 : fifo_rdata;

  rsp_overflow_a: assert property (@(posedge clk_i) disable iff (rst_i) !(mature && fifo_full));

endmodule
